// File: rtl/pcc_err_scan.sv
// Exhaustive error-scan driver for popcount-compare circuits: walks every pos/neg
// combination, checks the attached pcc decision, counts mismatches. Optional: PCC_SCAN_FIRSTERR_EN.
module pcc_err_scan #(
  parameter int NPOS    = 2,
  parameter int NNEG    = 4,
  parameter int DUT_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NPOS-1:0]      vec_pos,
  output logic [NNEG-1:0]      vec_neg,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [NPOS+NNEG:0]   err_count,
  output logic [NPOS+NNEG:0]   false_pos,
  output logic [NPOS+NNEG:0]   false_neg
`ifdef PCC_SCAN_FIRSTERR_EN
  ,
  output logic [NPOS+NNEG-1:0] first_err_idx,
  output logic                 first_err_vld
`endif
);

  localparam int IW = NPOS + NNEG;
  localparam logic [IW-1:0] IDX_LAST = '1;
  localparam logic [IW-1:0] IDX_ONE  = 1;
  localparam logic [IW:0]   CNT_ONE  = 1;
  localparam logic [1:0]    DRAIN_LAST = 2'(DUT_LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef PCC_SCAN_FIRSTERR_EN
  localparam int PW = IW + 2;
`else
  localparam int PW = 2;
`endif

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    drain_q, drain_d;
  logic          done_q, done_d;
  logic [IW:0]   err_q, err_d, fp_q, fp_d, fn_q, fn_d;
  logic          accept;
  logic          cur_exact, cur_vld, mismatch;
  logic [PW-1:0] cur_word, tap_word;

  function automatic logic [IW:0] pc(input logic [IW-1:0] v);
    logic [IW:0] c;
    c = '0;
    for (int i = 0; i < IW; i++) c = c + {{IW{1'b0}}, v[i]};
    return c;
  endfunction

  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign cur_vld   = (state_q == S_SCAN);
  assign cur_exact = pc({{NNEG{1'b0}}, idx_q[NPOS-1:0]}) >= pc({{NPOS{1'b0}}, idx_q[IW-1:NPOS]});

`ifdef PCC_SCAN_FIRSTERR_EN
  assign cur_word = {idx_q, cur_exact, cur_vld};
`else
  assign cur_word = {cur_exact, cur_vld};
`endif

  // The reference result travels alongside the vector so it lines up with dut_out.
  generate
    if (DUT_LAT == 0) begin : g_nodly
      assign tap_word = cur_word;
    end else begin : g_dly
      logic [PW-1:0] dly_q [DUT_LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DUT_LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= cur_word;
          for (int i = 1; i < DUT_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign tap_word = dly_q[DUT_LAT-1];
    end
  endgenerate

  assign mismatch = tap_word[0] && (dut_out != tap_word[1]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    fp_d  = fp_q;
    fn_d  = fn_q;
    if (accept) begin
      err_d = '0;
      fp_d  = '0;
      fn_d  = '0;
    end else if (mismatch) begin
      err_d = err_q + CNT_ONE;
      if (dut_out) fp_d = fp_q + CNT_ONE;
      else         fn_d = fn_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      drain_q <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fp_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fp_q    <= fp_d;
      fn_q    <= fn_d;
    end
  end

`ifdef PCC_SCAN_FIRSTERR_EN
  logic [IW-1:0] fe_idx_q, fe_idx_d;
  logic          fe_vld_q, fe_vld_d;

  always_comb begin
    fe_idx_d = fe_idx_q;
    fe_vld_d = fe_vld_q;
    if (accept) begin
      fe_idx_d = '0;
      fe_vld_d = 1'b0;
    end else if (mismatch && !fe_vld_q) begin
      fe_idx_d = tap_word[PW-1:2];
      fe_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_idx_q <= '0;
      fe_vld_q <= 1'b0;
    end else begin
      fe_idx_q <= fe_idx_d;
      fe_vld_q <= fe_vld_d;
    end
  end

  assign first_err_idx = fe_idx_q;
  assign first_err_vld = fe_vld_q;
`endif

  assign vec_pos   = idx_q[NPOS-1:0];
  assign vec_neg   = idx_q[IW-1:NPOS];
  assign busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done      = done_q;
  assign err_count = err_q;
  assign false_pos = fp_q;
  assign false_neg = fn_q;

endmodule

// File: tb/tb_pcc_err_scan.sv
// Bench for pcc_err_scan: two instances (DUT_LAT 0 and 2) driving an emulated pcc,
// table-driven scans, randomized approximate circuits, reset and start-perturbation corners.
module tb_pcc_err_scan;
  localparam int NPOS = 2;
  localparam int NNEG = 4;
  localparam int IW   = NPOS + NNEG;
  localparam int N    = 1 << IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  int   mode;
  logic err_map [N];

  logic [NPOS-1:0] vp0, vp2;
  logic [NNEG-1:0] vn0, vn2;
  logic            out0, out2, busy0, busy2, done0, done2;
  logic [IW:0]     err0, fp0, fn0, err2, fp2, fn2;
`ifdef PCC_SCAN_FIRSTERR_EN
  logic [IW-1:0]   fi0, fi2;
  logic            fv0, fv2;
`endif

  pcc_err_scan #(.NPOS(NPOS), .NNEG(NNEG), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .vec_pos(vp0), .vec_neg(vn0), .dut_out(out0),
    .busy(busy0), .done(done0), .err_count(err0), .false_pos(fp0), .false_neg(fn0)
`ifdef PCC_SCAN_FIRSTERR_EN
    , .first_err_idx(fi0), .first_err_vld(fv0)
`endif
  );

  pcc_err_scan #(.NPOS(NPOS), .NNEG(NNEG), .DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .vec_pos(vp2), .vec_neg(vn2), .dut_out(out2),
    .busy(busy2), .done(done2), .err_count(err2), .false_pos(fp2), .false_neg(fn2)
`ifdef PCC_SCAN_FIRSTERR_EN
    , .first_err_idx(fi2), .first_err_vld(fv2)
`endif
  );

  // Circuit under characterisation: 0 exact, 1 tied high, 2 tied low, 3 exact with error map.
  function automatic logic pcc_model(input int m, input logic [IW-1:0] idx);
    logic ex;
    ex = $countones(idx[NPOS-1:0]) >= $countones(idx[IW-1:NPOS]);
    case (m)
      0: return ex;
      1: return 1'b1;
      2: return 1'b0;
      default: return ex ^ err_map[idx];
    endcase
  endfunction

  always_comb out0 = pcc_model(mode, {vn0, vp0});

  logic d2a, d2b;
  always @(posedge clk) begin
    d2a <= pcc_model(mode, {vn2, vp2});
    d2b <= d2a;
  end
  assign out2 = d2b;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected statistics from the exact rule over all N combinations.
  task automatic ref_counts(input int m, output int e, output int fp, output int fn, output int first);
    e = 0; fp = 0; fn = 0; first = -1;
    for (int i = 0; i < N; i++) begin
      int  p, q;
      bit  ex, d;
      p  = $countones(i % (1 << NPOS));
      q  = $countones(i / (1 << NPOS));
      ex = (p >= q);
      d  = pcc_model(m, IW'(i));
      if (d != ex) begin
        e++;
        if (d) fp++; else fn++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic chk_counts(input string tag, input int e, input int fp, input int fn, input int first,
                            input logic [IW:0] ae, input logic [IW:0] afp, input logic [IW:0] afn);
    chk({tag, " err_count"}, int'(ae), e);
    chk({tag, " false_pos"}, int'(afp), fp);
    chk({tag, " false_neg"}, int'(afn), fn);
  endtask

  task automatic run_scan(input string tag, input int m, input bit perturb,
                          input int e, input int fp, input int fn, input int first);
    int dc0, dc2, nd0, nd2;
    mode = m;
    dc0 = -1; dc2 = -1; nd0 = 0; nd2 = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(negedge clk);
      start = perturb && (cyc == 20 || cyc == 65);
      if (cyc == 1) begin
        chk({tag, " busy0 rise"}, int'(busy0), 1);
        chk({tag, " busy2 rise"}, int'(busy2), 1);
      end
      if (done0) begin
        nd0++;
        if (dc0 < 0) begin
          dc0 = cyc;
          chk({tag, " busy0 at done"}, int'(busy0), 0);
          chk_counts({tag, " lat0"}, e, fp, fn, first, err0, fp0, fn0);
`ifdef PCC_SCAN_FIRSTERR_EN
          chk({tag, " lat0 first_err_vld"}, int'(fv0), int'(first >= 0));
          if (first >= 0) chk({tag, " lat0 first_err_idx"}, int'(fi0), first);
`endif
        end
      end
      if (done2) begin
        nd2++;
        if (dc2 < 0) begin
          dc2 = cyc;
          chk({tag, " busy2 at done"}, int'(busy2), 0);
          chk_counts({tag, " lat2"}, e, fp, fn, first, err2, fp2, fn2);
`ifdef PCC_SCAN_FIRSTERR_EN
          chk({tag, " lat2 first_err_vld"}, int'(fv2), int'(first >= 0));
          if (first >= 0) chk({tag, " lat2 first_err_idx"}, int'(fi2), first);
`endif
        end
      end
    end
    start = 1'b0;
    chk({tag, " lat0 done cycle"}, dc0, N + 2);
    chk({tag, " lat2 done cycle"}, dc2, N + 4);
    chk({tag, " lat0 done pulses"}, nd0, 1);
    chk({tag, " lat2 done pulses"}, nd2, 1);
    chk({tag, " lat0 held err"}, int'(err0), e);
    chk({tag, " lat2 held err"}, int'(err2), e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " vec0"}, int'({vn0, vp0}), 0);
    chk({tag, " vec2"}, int'({vn2, vp2}), 0);
    chk({tag, " busy0"}, int'(busy0), 0);
    chk({tag, " busy2"}, int'(busy2), 0);
    chk({tag, " done0"}, int'(done0), 0);
    chk({tag, " done2"}, int'(done2), 0);
    chk_counts({tag, " lat0"}, 0, 0, 0, -1, err0, fp0, fn0);
    chk_counts({tag, " lat2"}, 0, 0, 0, -1, err2, fp2, fn2);
`ifdef PCC_SCAN_FIRSTERR_EN
    chk({tag, " first_err_vld0"}, int'(fv0), 0);
    chk({tag, " first_err_vld2"}, int'(fv2), 0);
`endif
  endtask

  typedef struct {
    string name;
    int    mode;
    bit    perturb;
    int    e, fp, fn, first;
  } vec_t;

  vec_t tbl [4];

  initial begin
    tbl[0] = '{"exact",      0, 1'b0, 0,  0,  0,  -1};
    tbl[1] = '{"tie1",       1, 1'b0, 42, 42, 0,  4};
    tbl[2] = '{"tie0",       2, 1'b0, 22, 0,  22, 0};
    tbl[3] = '{"tie1_perturb", 1, 1'b1, 42, 42, 0, 4};

    rst = 1'b1; start = 1'b0; mode = 0;
    for (int i = 0; i < N; i++) err_map[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    for (int t = 0; t < 4; t++)
      run_scan(tbl[t].name, tbl[t].mode, tbl[t].perturb, tbl[t].e, tbl[t].fp, tbl[t].fn, tbl[t].first);

    // Reset in the middle of a scan, with start held high alongside it.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midscan idx0", int'({vn0, vp0}), 30);
    chk("midscan err0 nonzero", int'(err0 != 0), 1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_reset_state("midscan reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post reset err0 idle", int'(err0), 0);
    chk("post reset err2 idle", int'(err2), 0);
    chk("post reset busy2 idle", int'(busy2), 0);
    run_scan("after_reset", 1, 1'b0, 42, 42, 0, 4);

    for (int r = 0; r < 4; r++) begin
      int e, fp, fn, first;
      for (int i = 0; i < N; i++) err_map[i] = ($urandom_range(0, 3) == 0);
      ref_counts(3, e, fp, fn, first);
      run_scan($sformatf("random%0d", r), 3, r[0], e, fp, fn, first);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pcc_err_scan.md
# pcc_err_scan

Exhaustive error-scan driver for popcount-compare (pcc) circuits. On a start pulse it walks every combination of the `pos`/`neg` input vectors, drives them into an attached approximate pcc instance, and checks each returned decision against the exact `popcount(pos) >= popcount(neg)`. It then reports the mismatch statistics. It sits on the stimulus side of a pcc, in characterisation and self-test wrappers.

## Interface
- `NPOS`, default 2: width of the positive vector driven to the DUT.
- `NNEG`, default 4: width of the negative vector driven to the DUT.
- `DUT_LAT`, default 0: cycles between a vector appearing on `vec_pos`/`vec_neg` and its decision on `dut_out`. Legal range 0..3.

Ports:
- `clk`  in  1: the single clock; everything is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a scan. Honoured only in IDLE or DONE.
- `vec_pos`  out  NPOS: positive vector presented to the DUT.
- `vec_neg`  out  NNEG: negative vector presented to the DUT.
- `dut_out`  in  1: the DUT's comparison decision.
- `busy`  out  1: high in SCAN and DRAIN.
- `done`  out  1: one-cycle pulse when results become valid.
- `err_count`  out  NPOS+NNEG+1: total mismatches.
- `false_pos`  out  NPOS+NNEG+1: count of cases with `dut_out`=1 and exact=0.
- `false_neg`  out  NPOS+NNEG+1: count of cases with `dut_out`=0 and exact=1.

## Operation
- Let N = 2^(NPOS+NNEG). The vector index `idx` runs 0..N-1.
  - `vec_pos` = `idx[NPOS-1:0]`.
  - `vec_neg` = `idx[NPOS+NNEG-1:NPOS]`.
- The exact reference is computed from the registered vectors, delayed through a DUT_LAT-deep shift register together with a valid bit and `idx`. The reference is popcount(`vec_pos`) >= popcount(`vec_neg`), with both popcounts zero-extended to a common width.
- A mismatch is counted whenever the delayed valid bit is high and `dut_out` differs from the delayed exact result.
- State machine:
  - IDLE --start--> SCAN. On entry: `idx`←0 and all counters cleared.
  - SCAN: `idx` increments each cycle. When `idx`=N-1 → DRAIN.
  - DRAIN: lasts DUT_LAT+1 cycles so that the last result is counted, then → DONE.
  - DONE: `done`=1 for exactly the entry cycle; results are held. `start` returns to SCAN and clears the counters.
- `start` in SCAN or DRAIN is ignored.
- Counters cannot overflow, since the maximum value N fits in NPOS+NNEG+1 bits. `err_count` = `false_pos` + `false_neg` at all times.
- Outside SCAN, `vec_pos`/`vec_neg` hold their last value.

## Timing
- Reset values:
  - state=IDLE.
  - `vec_pos`=0, `vec_neg`=0.
  - `busy`=0, `done`=0.
  - all counters=0.
- Reset asserted mid-scan aborts immediately: IDLE, all counters zero, and the delay line valid bits cleared.
- Index 0 is presented the cycle after `start` is sampled. Index k's decision is sampled at `dut_out` DUT_LAT cycles after index k is presented.
- Total from `start` to `done`: N + DUT_LAT + 2 cycles.
- `busy` rises the cycle after `start` and falls in the same cycle that `done` rises.
- Counter outputs are registered. Final values are stable from the `done` cycle until the next accepted `start`.
- `start` coincident with `rst`: reset wins.

## Configuration
- `PCC_SCAN_FIRSTERR_EN` defined:
  - Adds output `first_err_idx` (NPOS+NNEG bits) and output `first_err_vld` (1 bit), which record the index of the first mismatch in the scan.
  - Both are cleared on reset and on an accepted `start`.
- Not defined: these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Exact model DUT, NPOS=2, NNEG=4, DUT_LAT=0; `start` → `done` 66 cycles later with `err_count`=0, `false_pos`=0, `false_neg`=0.
- `dut_out` tied 1 → `false_pos`=42, `false_neg`=0, `err_count`=42. With the macro defined: `first_err_idx`=4, `first_err_vld`=1.
- `dut_out` tied 0 → `false_neg`=22, `err_count`=22. `first_err_idx`=0.
- Exact model behind 2 register stages, DUT_LAT=2 → `err_count`=0, with `done` 68 cycles after `start`.
- `rst` at index 30 mid-scan → next cycle all outputs at reset values. Then `start` → a full clean scan with correct counts.
- `start` pulsed during SCAN and DRAIN → ignored: a single `done`, counts unchanged versus an unperturbed run.
